// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state, port owner and default widths.
package dmem_arbiter_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  typedef enum logic {
    ARB_CORE_OWN = 1'b0,
    ARB_LD_OWN   = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_LD   = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Ownership FSM for the data-memory arbiter: core priority with a starvation counter.
// DMEM_LD_BURST_EN lets a forced loader slot last up to BURST_LEN grants.
module dmem_arb_fsm
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   core_req,
  input  logic   ld_req,
  output owner_t owner
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);

  arb_state_t state;
  logic [3:0] wait_cnt;
  logic       ld_gnt;
  logic       ld_blocked;

  always_comb begin
    owner = OWNER_CORE;
    if (ld_req && (state == ARB_LD_OWN || !core_req)) begin
      owner = OWNER_LD;
    end
  end

  assign ld_gnt     = ld_req && (owner == OWNER_LD);
  assign ld_blocked = ld_req && core_req && (owner == OWNER_CORE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!ld_req || ld_gnt) begin
      wait_cnt <= '0;
    end else if (ld_blocked && wait_cnt != WAIT_SAT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

`ifdef DMEM_LD_BURST_EN
  localparam logic [2:0] BURST_LAST = 3'(BURST_LEN - 1);

  logic [2:0] burst_cnt;

  // In LD_OWN with ld_req high every cycle is a grant, so burst_cnt counts grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_CORE_OWN;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB_CORE_OWN: begin
          burst_cnt <= '0;
          if (ld_blocked && wait_cnt == WAIT_LAST) state <= ARB_LD_OWN;
        end
        ARB_LD_OWN: begin
          if (!ld_req || burst_cnt == BURST_LAST) begin
            state     <= ARB_CORE_OWN;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 3'd1;
          end
        end
        default: begin
          state     <= ARB_CORE_OWN;
          burst_cnt <= '0;
        end
      endcase
    end
  end
`else
  // BURST_LEN only shapes the slot length when bursts are enabled.
  logic unused_burst_len;
  assign unused_burst_len = (BURST_LEN > 0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_CORE_OWN;
    end else begin
      case (state)
        ARB_CORE_OWN: if (ld_blocked && wait_cnt == WAIT_LAST) state <= ARB_LD_OWN;
        ARB_LD_OWN:   state <= ARB_CORE_OWN;
        default:      state <= ARB_CORE_OWN;
      endcase
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline memory stage and the loader port.
// Optional DMEM_LD_BURST_EN: forced loader slots may last up to BURST_LEN grants.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 4,
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  owner_t owner;
  logic   ld_sel;

  dmem_arb_fsm #(
    .MAX_WAIT  (MAX_WAIT),
    .BURST_LEN (BURST_LEN)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .core_req (core_req),
    .ld_req   (ld_req),
    .owner    (owner)
  );

  assign ld_sel = (owner == OWNER_LD);

  // A stalled core store must never reach memory; the pipeline replays it.
  assign mem_a      = ld_sel ? ld_addr  : core_addr;
  assign mem_wd     = ld_sel ? ld_wdata : core_wdata;
  assign mem_we     = ld_sel ? ld_we    : (core_we && core_req);

  assign ld_gnt     = ld_req && ld_sel;
  assign core_stall = core_req && ld_sel;
  assign core_rdata = mem_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
    end else begin
      ld_rvalid <= ld_gnt && !ld_we;
      if (ld_gnt && !ld_we) ld_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic
// checked against a cycle-level model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_LEN = 4;
`ifdef DMEM_LD_BURST_EN
  localparam int SLOT = BURST_LEN;
`else
  localparam int SLOT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        preload;

  int checks = 0;
  int errors = 0;

  // Model state: blocked-cycle count, forced-slot flag, grants used in the slot.
  int          m_blocked, m_bursts;
  bit          m_forced, m_wins;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        last_gnt, last_stall, last_rvalid;
  logic [31:0] last_rdata;
  int          gnt_at;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_a[9:2]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_blocked = 0; m_bursts = 0; m_forced = 0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  // One clock cycle: inputs already driven right after the previous edge.
  task automatic step(input string tag);
    logic [31:0] ea, ewd, ld_word;
    logic        ewe;
    #2;
    m_wins  = ld_req && (m_forced || !core_req);
    ea      = m_wins ? ld_addr  : core_addr;
    ewd     = m_wins ? ld_wdata : core_wdata;
    ewe     = m_wins ? ld_we    : (core_we && core_req);
    ld_word = ref_mem[ld_addr[9:2]];
    chk({tag, "_gnt"},    ld_gnt,     m_wins);
    chk({tag, "_stall"},  core_stall, core_req && m_wins);
    chk({tag, "_mem_a"},  mem_a,      ea);
    chk({tag, "_mem_we"}, mem_we,     ewe);
    if (ewe) chk({tag, "_mem_wd"}, mem_wd, ewd);
    chk({tag, "_crdata"}, core_rdata, ref_mem[ea[9:2]]);
    chk({tag, "_rvalid"}, ld_rvalid,  m_rvalid);
    chk({tag, "_rdata"},  ld_rdata,   m_rdata);
    last_gnt = ld_gnt; last_stall = core_stall; last_rvalid = ld_rvalid; last_rdata = ld_rdata;
    @(posedge clk);
    if (ewe) ref_mem[ea[9:2]] = ewd;
    m_rvalid = m_wins && !ld_we;
    if (m_rvalid) m_rdata = ld_word;
    if (!ld_req) begin
      m_blocked = 0; m_forced = 0; m_bursts = 0;
    end else if (m_wins) begin
      m_blocked = 0;
      if (m_forced) begin
        m_bursts++;
        if (m_bursts >= SLOT) begin m_forced = 0; m_bursts = 0; end
      end
    end else begin
      m_blocked++;
      if (m_blocked >= MAX_WAIT) m_forced = 1;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; preload = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h104; core_wdata = '0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40; ld_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();

    // Reset with both ports requesting: core owns, nothing granted.
    @(posedge clk); #1; @(posedge clk); #1;
    preload = 1'b0;
    chk("rst_rvalid", ld_rvalid, 1'b0);
    chk("rst_rdata", ld_rdata, 32'h0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_gnt", ld_gnt, 1'b0);
    chk("rst_mem_a", mem_a, 32'h104);
    core_req = 1'b0;
    #1 chk("rst_gnt_idle", ld_gnt, 1'b1);
    ld_req = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Idle core: loader read served immediately, response one cycle later.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    step("idle");
    chk("idle_gnt_now", last_gnt, 1'b1);
    ld_req = 1'b0;
    step("idle_resp");
    chk("idle_rvalid", last_rvalid, 1'b1);
    chk("idle_rdata", last_rdata, 32'hDEADBEEF);

    // Starvation: continuous core loads, loader held high.
    core_req = 1'b1; core_we = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h44;
    for (int c = 0; c < MAX_WAIT + SLOT + 1; c++) begin
      core_addr = 32'($urandom_range(0, 63)) << 2;
      step("starve");
      chk("starve_slot_gnt", last_gnt, (c >= MAX_WAIT) && (c < MAX_WAIT + SLOT));
      chk("starve_slot_stall", last_stall, (c >= MAX_WAIT) && (c < MAX_WAIT + SLOT));
    end
    core_req = 1'b0; ld_req = 1'b0;
    step("drain");
    step("drain");

    // Conflicting stores to 0x80: core lands first, loader lands in its forced slot.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'h11;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h80; ld_wdata = 32'h22;
    step("conflict");
    chk("conflict_stall", last_stall, 1'b0);
    chk("conflict_core_wins", mem[32], 32'h11);
    core_we = 1'b0; core_addr = 32'h100;
    gnt_at = -1;
    for (int c = 1; c <= 20; c++) begin
      step("conflict_wait");
      if (last_gnt && gnt_at < 0) gnt_at = c;
      if (m_wins) ld_req = 1'b0;
      if (!ld_req && gnt_at >= 0) break;
    end
    ld_req = 1'b0;
    chk("conflict_latency", 64'(gnt_at), 64'(MAX_WAIT));
    chk("conflict_final", mem[32], 32'h22);
    core_req = 1'b0;
    step("idle2");

    // Reset asserted during the forced loader read slot.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10C;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h48;
    for (int c = 0; c < MAX_WAIT; c++) step("pre_rst");
    rst = 1'b0;
    #2;
    chk("midrst_gnt", ld_gnt, 1'b0);
    chk("midrst_stall", core_stall, 1'b0);
    chk("midrst_mem_a", mem_a, 32'h10C);
    chk("midrst_rdata_clr", ld_rdata, 32'h0);
    @(posedge clk); #1;
    chk("midrst_rvalid", ld_rvalid, 1'b0);
    core_req = 1'b0; ld_req = 1'b0;
    #3 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    core_req = 1'b1; ld_req = 1'b1;
    step("post_rst");
    chk("post_rst_core_own", last_gnt, 1'b0);

    // Random traffic against the model; the loader holds each request until granted.
    for (int n = 0; n < 400; n++) begin
      core_req   = ($urandom_range(0, 9) < 7);
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = 32'($urandom_range(0, 63)) << 2;
      core_wdata = $urandom;
      if (!ld_req && $urandom_range(0, 2) == 0) begin
        ld_req = 1'b1; ld_we = 1'($urandom_range(0, 1));
        ld_addr = 32'($urandom_range(0, 63)) << 2; ld_wdata = $urandom;
      end
      step("rand");
      if (m_wins) begin
        if ($urandom_range(0, 1) == 1) begin
          ld_we = 1'($urandom_range(0, 1));
          ld_addr = 32'($urandom_range(0, 63)) << 2; ld_wdata = $urandom;
        end else begin
          ld_req = 1'b0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
